beat_timer: RTL and testbench

Parametrised beat/bar timer for the audio-out path. Generates beat pulses from a programmable cycle period and tracks the beat index within an N-beat bar. It runs in one-shot mode (N beats, then a done pulse) or periodic mode (bar wrap with a bar pulse). It adds start/stop/pause control and a busy flag for the note sequencer and the bus-facing control registers.

---
 rtl/beat_timer_if.sv | 26 ++
 rtl/beat_timer.sv | 82 ++++++++
 tb/tb_beat_timer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/beat_timer_if.sv
// beat_timer_if: control inputs and tick/status outputs of beat_timer.
interface beat_timer_if #(
  parameter int CNT_W  = 28,
  parameter int BEAT_W = 8
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              mode;
  logic [CNT_W-1:0]  period;
  logic [BEAT_W-1:0] beats;
  logic              beat_tick;
  logic              bar_tick;
  logic              done;
  logic              half_tick;
  logic [BEAT_W-1:0] beat_idx;
  logic              busy;
  modport master (
    output start, stop, pause, mode, period, beats,
    input  beat_tick, bar_tick, done, half_tick, beat_idx, busy
  );
  modport slave (
    input  start, stop, pause, mode, period, beats,
    output beat_tick, bar_tick, done, half_tick, beat_idx, busy
  );
endinterface

// File: rtl/beat_timer.sv
// beat_timer: beat/bar timer with one-shot or periodic bars, pause and restart.
// Define BEAT_TIMER_HALF_EN to enable the mid-beat half_tick pulse.
module beat_timer #(
  parameter int CNT_W  = 28,
  parameter int BEAT_W = 8
) (
  input logic        clk,
  input logic        rst,
  beat_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t            state;
  logic [CNT_W-1:0]  cnt, p_q;
  logic [BEAT_W-1:0] idx, n_q;
  logic              m_q, beat_q, bar_q, done_q, busy_q;
  logic              step, wrap, last;
  // A PAUSE cycle with pause low already counts, so a beat stretches by exactly the paused edges.
  assign step = state != IDLE && !bus.pause;
  assign wrap = cnt == p_q;
  assign last = idx == n_q - BEAT_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      p_q    <= '0;
      idx    <= '0;
      n_q    <= '0;
      m_q    <= 1'b0;
      beat_q <= 1'b0;
      bar_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      beat_q <= 1'b0;
      bar_q  <= 1'b0;
      done_q <= 1'b0;
      if (bus.stop) begin
        state  <= IDLE;
        cnt    <= '0;
        idx    <= '0;
        busy_q <= 1'b0;
      end else if (bus.start) begin
        state  <= RUN;
        p_q    <= bus.period;
        n_q    <= bus.beats;
        m_q    <= bus.mode;
        cnt    <= '0;
        idx    <= '0;
        busy_q <= 1'b1;
      end else if (state != IDLE) begin
        if (bus.pause) state <= PAUSE;
        else begin
          state <= RUN;
          cnt   <= wrap ? '0 : cnt + CNT_W'(1);
          if (wrap) begin
            beat_q <= 1'b1;
            idx    <= last ? '0 : idx + BEAT_W'(1);
            bar_q  <= last && m_q;
            done_q <= last && !m_q;
            if (last && !m_q) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
      end
    end
`ifdef BEAT_TIMER_HALF_EN
  logic half_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) half_q <= 1'b0;
    else half_q <= !bus.stop && !bus.start && step && p_q != '0 && cnt == (p_q >> 1);
  assign bus.half_tick = half_q;
`else
  assign bus.half_tick = 1'b0;
`endif
  assign bus.beat_tick = beat_q;
  assign bus.bar_tick  = bar_q;
  assign bus.done      = done_q;
  assign bus.beat_idx  = idx;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_beat_timer.sv
// tb_beat_timer: directed vector table plus hand sequences for beat_timer.
module tb_beat_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  beat_timer_if #(.CNT_W(28), .BEAT_W(8)) bus();
  beat_timer #(.CNT_W(28), .BEAT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef BEAT_TIMER_HALF_EN
  localparam int HALF = 1;
`else
  localparam int HALF = 0;
`endif
  int vecs = 0;
  int errs = 0;
  typedef struct {
    logic m;
    int   p, n, ncyc;
    int   ticks, bars, dones, halves, idx, busy;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic m, input int p, input int n);
    bus.mode   = m;
    bus.period = 28'(p);
    bus.beats  = 8'(n);
    bus.start  = 1'b1;
    step(1);
    bus.start  = 1'b0;
  endtask

  task automatic halt;
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
  endtask

  initial begin
    int t, b, d, h;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.mode = 0; bus.period = '0; bus.beats = '0;
    //         m   P  N  cyc  ticks bars dones halves idx busy
    tbl[0] = '{1'b1, 2, 4,  24,   8,   2,   0,   8,     0,  1};
    tbl[1] = '{1'b0, 0, 0, 260, 256,   0,   1,   0,     0,  0};
    tbl[2] = '{1'b0, 4, 3,  20,   3,   0,   1,   3,     0,  0};
    tbl[3] = '{1'b1, 0, 1,  10,  10,  10,   0,   0,     0,  1};
    tbl[4] = '{1'b0, 1, 5,   7,   3,   0,   0,   4,     3,  1};
    tbl[5] = '{1'b1, 3, 2,  13,   3,   1,   0,   3,     1,  1};
    step(2);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tick", int'(bus.beat_tick), 0);
    chk("rst_idx", int'(bus.beat_idx), 0);
    rst = 1'b0;
    step(1);
    for (int i = 0; i < 6; i++) begin
      go(tbl[i].m, tbl[i].p, tbl[i].n);
      t = 0; b = 0; d = 0; h = 0;
      for (int c = 0; c < tbl[i].ncyc; c++) begin
        step(1);
        t += int'(bus.beat_tick);
        b += int'(bus.bar_tick);
        d += int'(bus.done);
        h += int'(bus.half_tick);
      end
      chk($sformatf("v%0d_ticks", i), t, tbl[i].ticks);
      chk($sformatf("v%0d_bars", i), b, tbl[i].bars);
      chk($sformatf("v%0d_dones", i), d, tbl[i].dones);
      chk($sformatf("v%0d_halves", i), h, HALF * tbl[i].halves);
      chk($sformatf("v%0d_idx", i), int'(bus.beat_idx), tbl[i].idx);
      chk($sformatf("v%0d_busy", i), int'(bus.busy), tbl[i].busy);
      halt;
    end
    // one-shot exact edges
    go(1'b0, 4, 3);
    chk("os_busy0", int'(bus.busy), 1);
    step(4);
    chk("os_e4_tick", int'(bus.beat_tick), 0);
    step(1);
    chk("os_e5_tick", int'(bus.beat_tick), 1);
    chk("os_e5_idx", int'(bus.beat_idx), 1);
    step(5);
    chk("os_e10_tick", int'(bus.beat_tick), 1);
    chk("os_e10_idx", int'(bus.beat_idx), 2);
    step(4);
    chk("os_e14_busy", int'(bus.busy), 1);
    chk("os_e14_done", int'(bus.done), 0);
    step(1);
    chk("os_e15_tick", int'(bus.beat_tick), 1);
    chk("os_e15_done", int'(bus.done), 1);
    chk("os_e15_busy", int'(bus.busy), 0);
    chk("os_e15_idx", int'(bus.beat_idx), 0);
    step(1);
    chk("os_e16_done", int'(bus.done), 0);
    chk("os_e16_tick", int'(bus.beat_tick), 0);
    // pause stretches a beat by the paused cycles, then stop mid-beat
    go(1'b1, 9, 4);
    step(3);
    bus.pause = 1'b1;
    step(7);
    bus.pause = 1'b0;
    chk("pz_hold_tick", int'(bus.beat_tick), 0);
    chk("pz_hold_busy", int'(bus.busy), 1);
    step(6);
    chk("pz_e16_tick", int'(bus.beat_tick), 0);
    step(1);
    chk("pz_e17_tick", int'(bus.beat_tick), 1);
    chk("pz_e17_idx", int'(bus.beat_idx), 1);
    step(4);
    halt;
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_idx", int'(bus.beat_idx), 0);
    chk("stop_done", int'(bus.done), 0);
    t = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      t += int'(bus.beat_tick) + int'(bus.done);
    end
    chk("stop_quiet", t, 0);
    // restart while cnt==P suppresses the tick
    go(1'b0, 4, 3);
    step(4);
    go(1'b0, 4, 3);
    chk("rs_tick", int'(bus.beat_tick), 0);
    chk("rs_idx", int'(bus.beat_idx), 0);
    chk("rs_busy", int'(bus.busy), 1);
    step(4);
    chk("rs_e4_tick", int'(bus.beat_tick), 0);
    step(1);
    chk("rs_e5_tick", int'(bus.beat_tick), 1);
    chk("rs_e5_idx", int'(bus.beat_idx), 1);
    halt;
    // mid-beat half tick
    go(1'b1, 9, 4);
    step(4);
    chk("hf_e4", int'(bus.half_tick), 0);
    step(1);
    chk("hf_e5", int'(bus.half_tick), HALF);
    step(1);
    chk("hf_e6", int'(bus.half_tick), 0);
    step(9);
    chk("hf_e15", int'(bus.half_tick), HALF);
    halt;
    // asynchronous reset while a tick is high
    go(1'b0, 9, 4);
    step(10);
    chk("ar_pre_tick", int'(bus.beat_tick), 1);
    rst = 1'b1;
    #1;
    chk("ar_tick", int'(bus.beat_tick), 0);
    chk("ar_busy", int'(bus.busy), 0);
    chk("ar_idx", int'(bus.beat_idx), 0);
    step(1);
    rst = 1'b0;
    t = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      t += int'(bus.beat_tick) + int'(bus.busy);
    end
    chk("ar_quiet", t, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
